// File: rtl/test_mem.sv
// Small register-array lookup memory preloaded with a constant byte table.
// Registered read (read-before-write), optional run-time patching, async reset restores the table.
module test_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Table repeats every 8 entries; bytes are zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] reset_val(input int unsigned idx);
        logic [2:0] sel;
        logic [7:0] b;
        sel = 3'(idx);
        unique case (sel)
            3'd0:    b = 8'h3C;
            3'd1:    b = 8'hA5;
            3'd2:    b = 8'h0F;
            3'd3:    b = 8'hF0;
            3'd4:    b = 8'h55;
            3'd5:    b = 8'hAA;
            3'd6:    b = 8'h81;
            default: b = 8'h7E;
        endcase
        return DATA_W'(b);
    endfunction

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[addr] = wr_data;
        end
        // Read sees the pre-write contents of the same edge.
        data_d = mem_q[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= reset_val(i);
            end
            data_q <= '0;
        end else begin
            mem_q  <= mem_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_test_mem.sv
// Scoreboard bench for test_mem: a reference memory model pushes expected read data
// when each edge is driven; the value is popped and compared just after the edge.
module tb_test_mem;

    logic       clk;
    logic       rst_n;
    logic [2:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] model [8];
    logic [7:0] exp_q [$];
    logic [7:0] last_exp;

    test_mem #(
        .DATA_W(8),
        .ADDR_W(3)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        logic [7:0] tbl [8];
        tbl = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h81, 8'h7E};
        for (int i = 0; i < 8; i++) model[i] = tbl[i];
    endtask

    // Predict the edge, push expectation, clock it, then pop and compare.
    task automatic step(input string tag);
        logic [7:0] e;
        if (!rst_n) begin
            e = 8'h00;
        end else begin
            e = model[addr];
            if (wr_en) model[addr] = wr_data;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'hFF, 8'h00);
        end else begin
            check($sformatf("%s_a%0d", tag, addr), data, exp_q.pop_front());
        end
        last_exp = e;
    endtask

    task automatic assert_reset_async(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag, data, 8'h00);
        last_exp = 8'h00;
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        model_reset();
        #2;
        check("reset_data", data, 8'h00);
        step("in_reset");
        rst_n = 1'b1;

        // Sequential sweep 0..5, 10 cycles each
        for (int a = 0; a < 6; a++) begin
            addr = 3'(a);
            for (int k = 0; k < 10; k++) step("sweep");
        end

        // Remaining entries and wrap back to 0
        addr = 3'd6; step("full");
        addr = 3'd7; step("full");
        addr = 3'd0; step("wrap");

        // Address changes between edges must not disturb data
        #2 addr = 3'd4;
        #1 check("hold_mid1", data, last_exp);
        #1 addr = 3'd7;
        #1 check("hold_mid2", data, last_exp);
        step("after_hold");

        // Write then read: old value on the write edge, new value next
        addr = 3'd3; wr_en = 1'b1; wr_data = 8'h99;
        step("rbw_old");
        wr_en = 1'b0;
        step("rbw_new");
        check("rbw_new_const", data, 8'h99);
        addr = 3'd2; step("neighbour");
        addr = 3'd3; step("pre_rst");

        // Asynchronous reset between edges
        #2;
        assert_reset_async("async_rst");
        #2;
        rst_n = 1'b1;
        addr  = 3'd3;
        step("restored");
        check("restored_const", data, 8'hF0);

        // Write attempted while reset is held across the edge
        #2;
        assert_reset_async("rst_write_zero");
        addr = 3'd5; wr_en = 1'b1; wr_data = 8'h12;
        step("rst_write_edge");
        wr_en = 1'b0;
        rst_n = 1'b1;
        step("rst_write_after");
        check("rst_write_const", data, 8'hAA);

        // Back-to-back writes then readback
        wr_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr    = 3'(a);
            wr_data = 8'(a + 1);
            step("b2b_wr");
        end
        wr_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            step("b2b_rd");
        end
        check("b2b_last_const", data, 8'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
